// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks.
// Segment vectors here are logical (1 = lit), bit0 = a .. bit6 = g.
package seg7_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Logical "all segments dark" pattern, before any output polarity is applied.
    localparam seg_t SEG_OFF = 7'h00;

    // Hex glyph table. Entry 15 sits in the MSB position, so HEX_TABLE[n] is glyph n.
    localparam logic [15:0][SEG_W-1:0] HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Glyph lookup, usable in any block that needs a combinational decode.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return HEX_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to logical 7-segment pattern (1 = lit, bit0 = a).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nib_i,
    output logic [SEG_W-1:0] seg_o
);

    // Straight table lookup; no polarity handling here so every display block can share it.
    always_comb begin
        seg_o = hex_to_seg(nib_i);
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver.
// A refresh counter splits time into digit slots; the first cycle of each slot is
// blanked so the previous digit's segments never bleed into the next anode.
// Everything visible at the pins is registered, polarity applied only at the flops.
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,        // 1..8
    parameter int REFRESH_DIV = 100000,   // cycles per digit slot, >= 2
    parameter bit ACTIVE_LOW  = 1'b1      // 1: common anode, outputs low = on
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*N_DIGITS-1:0]     data,
    input  logic [SEG_W*N_DIGITS-1:0] raw_seg,
    input  logic                      raw_mode,
    input  logic [N_DIGITS-1:0]       dp,
    input  logic [N_DIGITS-1:0]       digit_en,
    output logic [SEG_W-1:0]          catodo,
    output logic                      punto,
    output logic [N_DIGITS-1:0]       anodo,
    output logic                      scan_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Scan state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Registered pin drivers (already polarity-adjusted)
    logic [SEG_W-1:0]    catodo_q, catodo_d;
    logic                punto_q,  punto_d;
    logic [N_DIGITS-1:0] anodo_q,  anodo_d;
    logic                tick_q,   tick_d;

    // Per-slot selections from the live inputs
    logic [3:0]          sel_nib;
    logic [SEG_W-1:0]    sel_raw;
    logic                sel_dp;
    logic                sel_en;
    logic [N_DIGITS-1:0] sel_onehot;
    logic [SEG_W-1:0]    hex_seg;

    // Logical (active-high) next outputs before the polarity stage
    logic                blank;
    logic                lit;
    logic [SEG_W-1:0]    seg_log;
    logic [SEG_W-1:0]    cat_log;
    logic                pt_log;
    logic [N_DIGITS-1:0] an_log;

    // Pick the current digit's fields. A compare loop keeps every part-select
    // constant, which stays clean for any N_DIGITS including 1.
    always_comb begin
        sel_nib    = '0;
        sel_raw    = SEG_OFF;
        sel_dp     = 1'b0;
        sel_en     = 1'b0;
        sel_onehot = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_nib       = data[4*k +: 4];
                sel_raw       = raw_seg[SEG_W*k +: SEG_W];
                sel_dp        = dp[k];
                sel_en        = digit_en[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    seg7_hex_decode u_hex (
        .nib_i (sel_nib),
        .seg_o (hex_seg)
    );

    // Slot timing: counter wraps at the end of a slot and moves to the next digit.
    always_comb begin
        tick_d = (cnt_q == CNT_LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        if (tick_d) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Logical outputs: blank on the slot's first cycle or for a disabled digit.
    always_comb begin
        blank   = (cnt_q == '0);
        lit     = !blank && sel_en;
        seg_log = raw_mode ? sel_raw : hex_seg;
        cat_log = lit ? seg_log : SEG_OFF;
        pt_log  = lit && sel_dp;
        an_log  = lit ? sel_onehot : '0;
    end

    // Polarity stage: flip to the board's drive sense right before the flops.
    always_comb begin
        catodo_d = cat_log ^ {SEG_W{ACTIVE_LOW}};
        punto_d  = pt_log ^ ACTIVE_LOW;
        anodo_d  = an_log ^ {N_DIGITS{ACTIVE_LOW}};
    end

    // State and output registers; reset parks every pin in its inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            tick_q   <= 1'b0;
            catodo_q <= {SEG_W{ACTIVE_LOW}};
            punto_q  <= ACTIVE_LOW;
            anodo_q  <= {N_DIGITS{ACTIVE_LOW}};
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tick_q   <= tick_d;
            catodo_q <= catodo_d;
            punto_q  <= punto_d;
            anodo_q  <= anodo_d;
        end
    end

    assign catodo    = catodo_q;
    assign punto     = punto_q;
    assign anodo     = anodo_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver: a 4-digit active-low instance and a 1-digit
// active-high instance share clock, reset and raw_mode. A per-cycle reference
// pushes expected pin values at each rising edge; they are compared at the
// following falling edge. Scenario steps add explicit constant checks.
module tb_seg7_mux_driver;

    localparam int DIV = 4;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [6:0] cat;
        logic       pt;
        logic [3:0] an;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        raw_mode;
    logic [15:0] data0;
    logic [27:0] raw0;
    logic [3:0]  dp0, en0;
    logic [6:0]  catodo0;
    logic        punto0, tick0;
    logic [3:0]  anodo0;
    logic [3:0]  data1;
    logic [6:0]  raw1;
    logic        dp1, en1;
    logic [6:0]  catodo1;
    logic        punto1, tick1;
    logic        anodo1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   m_cnt = 0;
    int   m_idx = 0;

    always #5 clk = ~clk;

    seg7_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut0 (
        .clk (clk), .rst (rst), .data (data0), .raw_seg (raw0), .raw_mode (raw_mode),
        .dp (dp0), .digit_en (en0), .catodo (catodo0), .punto (punto0),
        .anodo (anodo0), .scan_tick (tick0)
    );

    seg7_mux_driver #(.N_DIGITS(1), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut1 (
        .clk (clk), .rst (rst), .data (data1), .raw_seg (raw1), .raw_mode (raw_mode),
        .dp (dp1), .digit_en (en1), .catodo (catodo1), .punto (punto1),
        .anodo (anodo1), .scan_tick (tick1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference output for one cycle given slot position, digit and live inputs.
    function automatic exp_t model(input int cnt, input int idx, input bit al, input logic r,
                                   input logic [15:0] d, input logic [27:0] rs, input logic rm,
                                   input logic [3:0] p, input logic [3:0] en);
        exp_t e;
        e = '0;
        if (!r) begin
            e.tick = (cnt == DIV - 1);
            if (cnt != 0 && en[idx]) begin
                e.cat     = rm ? rs[7*idx +: 7] : HEX_TAB[d[4*idx +: 4]];
                e.pt      = p[idx];
                e.an[idx] = 1'b1;
            end
        end
        if (al) begin
            e.cat = ~e.cat;
            e.pt  = ~e.pt;
            e.an  = ~e.an;
        end
        return e;
    endfunction

    // Reference scan position; expectations queued at each active edge.
    always @(posedge clk) begin
        q0.push_back(model(m_cnt, m_idx, 1'b1, rst, data0, raw0, raw_mode, dp0, en0));
        q1.push_back(model(m_cnt, 0, 1'b0, rst, 16'(data1), 28'(raw1), raw_mode,
                           4'(dp1), 4'(en1)));
        if (rst) begin
            m_cnt <= 0;
            m_idx <= 0;
        end else if (m_cnt == DIV - 1) begin
            m_cnt <= 0;
            m_idx <= (m_idx + 1) % 4;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Scoreboard compare on the opposite edge.
    always @(negedge clk) begin
        if (q0.size() > 0 && q1.size() > 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            chk("sb_cat0",  32'(catodo0), 32'(e0.cat));
            chk("sb_pt0",   32'(punto0),  32'(e0.pt));
            chk("sb_an0",   32'(anodo0),  32'(e0.an));
            chk("sb_tick0", 32'(tick0),   32'(e0.tick));
            chk("sb_cat1",  32'(catodo1), 32'(e1.cat));
            chk("sb_pt1",   32'(punto1),  32'(e1.pt));
            chk("sb_an1",   32'(anodo1),  32'(e1.an[0]));
            chk("sb_tick1", 32'(tick1),   32'(e1.tick));
        end
    end

    task automatic rand_inputs();
        data0    = 16'($urandom);
        raw0     = 28'($urandom);
        dp0      = 4'($urandom);
        en0      = 4'($urandom);
        raw_mode = 1'($urandom);
        data1    = 4'($urandom);
        raw1     = 7'($urandom);
        dp1      = 1'($urandom);
        en1      = 1'($urandom);
    endtask

    // Wait (bounded) for the last active cycle of the digit whose anode pattern is pat.
    task automatic sync_last(input string tag, input logic [3:0] pat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tick0 === 1'b1 && anodo0 === pat) && n < 40);
        chk(tag, 32'(tick0 === 1'b1 && anodo0 === pat), 32'd1);
    endtask

    task automatic spot(input string tag, input logic [3:0] pat, input logic [6:0] cat,
                        input logic pt);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (anodo0 !== pat && n < 40);
        chk({tag, "_an"},  32'(anodo0),  32'(pat));
        chk({tag, "_cat"}, 32'(catodo0), 32'(cat));
        chk({tag, "_pt"},  32'(punto0),  32'(pt));
    endtask

    initial begin
        int   n;
        logic seen_d1;
        logic [3:0] pat1;

        // Reset held 3 cycles with random inputs
        rst = 1'b1;
        rand_inputs();
        repeat (3) begin
            @(negedge clk);
            chk("rst_an0",   32'(anodo0),  32'hF);
            chk("rst_cat0",  32'(catodo0), 32'h7F);
            chk("rst_pt0",   32'(punto0),  32'd1);
            chk("rst_tick0", 32'(tick0),   32'd0);
            chk("rst_an1",   32'(anodo1),  32'd0);
            chk("rst_cat1",  32'(catodo1), 32'h00);
            rand_inputs();
        end

        // Hex scan
        rst      = 1'b0;
        raw_mode = 1'b0;
        data0    = 16'h3A5F;
        dp0      = 4'b0100;
        en0      = 4'hF;
        data1    = 4'h1;
        dp1      = 1'b0;
        en1      = 1'b1;
        @(negedge clk);
        chk("rel_blank_an", 32'(anodo0), 32'hF);
        @(negedge clk);
        chk("rel_d0_an",  32'(anodo0),  32'hE);
        chk("rel_d0_cat", 32'(catodo0), 32'h0E);
        spot("hex_d1", 4'b1101, 7'h12, 1'b1);
        spot("hex_d2", 4'b1011, 7'h08, 1'b0);
        spot("hex_d3", 4'b0111, 7'h30, 1'b1);
        spot("hex_d0", 4'b1110, 7'h0E, 1'b1);
        n = 0;
        while (tick0 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (tick0 !== 1'b1 && n < 10);
        chk("tick_period", 32'(n), 32'd4);

        // Degenerate instance: blank then three active cycles, glyph '1'
        n = 0;
        while (tick1 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        pat1 = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("deg_an",  32'(anodo1),  32'(pat1[i]));
            chk("deg_cat", 32'(catodo1), pat1[i] ? 32'h06 : 32'h00);
        end

        // Raw mode with digit 1 disabled
        raw_mode = 1'b1;
        raw0     = {7'h55, 7'h2A, 7'h49, 7'h36};
        en0      = 4'b1101;
        spot("raw_d0", 4'b1110, 7'h49, 1'b1);
        spot("raw_d2", 4'b1011, 7'h55, 1'b0);
        seen_d1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (anodo0 !== 4'hF && anodo0[1] === 1'b0) seen_d1 = 1'b1;
        end
        chk("raw_d1_dark", 32'(seen_d1), 32'd0);

        // Wrap 3 -> 0 and mid-slot data change
        raw_mode = 1'b0;
        en0      = 4'hF;
        data0    = 16'h3A50;
        sync_last("wrap_sync", 4'b0111);
        @(negedge clk);
        chk("wrap_blank", 32'(anodo0), 32'hF);
        @(negedge clk);
        chk("wrap_d0_an",  32'(anodo0),  32'hE);
        chk("wrap_d0_cat", 32'(catodo0), 32'h40);
        data0 = 16'h3A58;
        @(negedge clk);
        chk("upd_cat", 32'(catodo0), 32'h00);

        // Reset mid-scan during digit 2
        sync_last("mid_sync", 4'b1101);
        @(negedge clk);
        @(negedge clk);
        chk("mid_d2_an", 32'(anodo0), 32'hB);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_an",   32'(anodo0),  32'hF);
        chk("mid_rst_cat",  32'(catodo0), 32'h7F);
        chk("mid_rst_pt",   32'(punto0),  32'd1);
        chk("mid_rst_tick", 32'(tick0),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_blank", 32'(anodo0), 32'hF);
        @(negedge clk);
        chk("mid_d0_an", 32'(anodo0), 32'hE);

        // Random inputs, scoreboard only
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            rand_inputs();
        end
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
